// File: rtl/ucode_sequencer.sv
// ucode_sequencer
// Sits between fetch and issue. Ordinary instructions pass straight through.
// A multiply opcode is consumed, fetch is stalled, the operand fields are
// latched and presented to ucode_rom, and the ROM's micro-words are injected
// into issue until a halt word ends the sequence. Taken micro-branches squash
// the two wrong-path words already in flight. Runaway sequences (timeout or
// micro-address overflow) are aborted with a one-cycle ucode_err pulse.
//
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   fetch_instruction/_valid  instruction from fetch
//   fetch_stall          fetch must hold its current instruction
//   mul_opcode, immediate, dest_reg, reg1, reg2, ghost_pc  to ucode_rom
//   ucode_instruction    ROM word (registered, 1-cycle latency from ghost_pc)
//   ucode_done           ROM halt indication (one cycle after halt word)
//   ubr_taken/ubr_target micro-branch redirect from downstream
//   issue_instruction/_valid/_is_ucode  to issue
//   ucode_err            one-cycle pulse on abort
module ucode_sequencer #(
    parameter int UPC_W       = 4,
    parameter int MAX_UCYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       fetch_instruction,
    input  logic              fetch_valid,
    output logic              fetch_stall,
    output logic [6:0]        mul_opcode,
    output logic [15:0]       immediate,
    output logic [3:0]        dest_reg,
    output logic [3:0]        reg1,
    output logic [3:0]        reg2,
    output logic [UPC_W-1:0]  ghost_pc,
    input  logic [31:0]       ucode_instruction,
    input  logic              ucode_done,
    input  logic              ubr_taken,
    input  logic [UPC_W-1:0]  ubr_target,
    output logic [31:0]       issue_instruction,
    output logic              issue_valid,
    output logic              issue_is_ucode,
    output logic              ucode_err
);

    localparam int CNT_W = $clog2(MAX_UCYCLES + 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, WAIT_DONE} state_t;

    state_t             state_q, state_d;
    logic [UPC_W-1:0]   ghost_pc_q, ghost_pc_d;
    logic [6:0]         mul_opcode_q, mul_opcode_d;
    logic [15:0]        immediate_q, immediate_d;
    logic [3:0]         dest_reg_q, dest_reg_d;
    logic [3:0]         reg1_q, reg1_d;
    logic [3:0]         reg2_q, reg2_d;
    logic [CNT_W-1:0]   ucnt_q, ucnt_d;
    logic               squash_q, squash_d;
    logic               ucode_err_q, ucode_err_d;

    logic [CNT_W-1:0]   ucnt_inc;
    logic               fetch_is_mul;
    logic               ucode_is_halt;
    logic               overflow;
    logic               issue_valid_c;

    assign fetch_is_mul  = fetch_instruction[31:25] inside
                           {7'b0010000, 7'b0011000, 7'b0110000, 7'b0111000};
    assign ucode_is_halt = (ucode_instruction[31:28] == 4'b1101);
    assign ucnt_inc      = ucnt_q + CNT_W'(1);

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d           = state_q;
        ghost_pc_d        = ghost_pc_q;
        mul_opcode_d      = mul_opcode_q;
        immediate_d       = immediate_q;
        dest_reg_d        = dest_reg_q;
        reg1_d            = reg1_q;
        reg2_d            = reg2_q;
        ucnt_d            = ucnt_q;
        squash_d          = squash_q;
        ucode_err_d       = 1'b0;
        overflow          = 1'b0;
        issue_instruction = fetch_instruction;
        issue_valid_c     = 1'b0;
        issue_is_ucode    = 1'b0;

        case (state_q)
            IDLE: begin
                issue_valid_c = fetch_valid & ~fetch_is_mul;
                if (fetch_valid && fetch_is_mul) begin
                    mul_opcode_d = fetch_instruction[31:25];
                    dest_reg_d   = fetch_instruction[24:21];
                    reg1_d       = fetch_instruction[20:17];
                    reg2_d       = fetch_instruction[16:13];
                    immediate_d  = fetch_instruction[15:0];
                    ghost_pc_d   = '0;
                    ucnt_d       = '0;
                    squash_d     = 1'b0;
                    state_d      = FILL;
                end
            end
            FILL: begin
                // ROM is registering word 0 this cycle; start fetching word 1.
                ucnt_d     = ucnt_inc;
                ghost_pc_d = UPC_W'(1);
                state_d    = RUN;
            end
            RUN: begin
                ucnt_d            = ucnt_inc;
                issue_instruction = ucode_instruction;
                issue_is_ucode    = 1'b1;
                if (ubr_taken) begin
                    // Word on the ROM output now and the one registered this
                    // edge are both wrong-path; redirect and squash both.
                    ghost_pc_d = ubr_target;
                    squash_d   = 1'b1;
                end else if (squash_q) begin
                    squash_d = 1'b0;
                    if (&ghost_pc_q) overflow = 1'b1;
                    else             ghost_pc_d = ghost_pc_q + UPC_W'(1);
                end else if (ucode_is_halt) begin
                    state_d = WAIT_DONE;
                end else if (&ghost_pc_q) begin
                    overflow = 1'b1;
                end else begin
                    issue_valid_c = 1'b1;
                    ghost_pc_d    = ghost_pc_q + UPC_W'(1);
                end
            end
            WAIT_DONE: begin
                ucnt_d = ucnt_inc;
                if (ucode_done) begin
                    mul_opcode_d = '0;
                    state_d      = IDLE;
                end
            end
        endcase

        // Abort overrides whatever the state decided this cycle.
        if (overflow || ((state_q != IDLE) && (ucnt_inc == CNT_W'(MAX_UCYCLES)))) begin
            state_d       = IDLE;
            mul_opcode_d  = '0;
            ghost_pc_d    = '0;
            squash_d      = 1'b0;
            ucode_err_d   = 1'b1;
            issue_valid_c = 1'b0;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ghost_pc_q   <= '0;
            mul_opcode_q <= '0;
            immediate_q  <= '0;
            dest_reg_q   <= '0;
            reg1_q       <= '0;
            reg2_q       <= '0;
            ucnt_q       <= '0;
            squash_q     <= 1'b0;
            ucode_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ghost_pc_q   <= ghost_pc_d;
            mul_opcode_q <= mul_opcode_d;
            immediate_q  <= immediate_d;
            dest_reg_q   <= dest_reg_d;
            reg1_q       <= reg1_d;
            reg2_q       <= reg2_d;
            ucnt_q       <= ucnt_d;
            squash_q     <= squash_d;
            ucode_err_q  <= ucode_err_d;
        end
    end

    assign fetch_stall = (state_q != IDLE);
    // Passthrough is combinational, so reset gates it explicitly.
    assign issue_valid = rst & issue_valid_c;
    assign mul_opcode  = mul_opcode_q;
    assign immediate   = immediate_q;
    assign dest_reg    = dest_reg_q;
    assign reg1        = reg1_q;
    assign reg2        = reg2_q;
    assign ghost_pc    = ghost_pc_q;
    assign ucode_err   = ucode_err_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Testbench for ucode_sequencer. A small ROM model answers ghost_pc with a
// one-cycle registered word; ucode_done follows the halt word by one cycle.
// Stimulus pushes expected issued words into a queue; a monitor pops and
// compares whenever issue_valid is seen.
module tb_ucode_sequencer;

    localparam logic [31:0] PT0   = 32'h6200_0000;
    localparam logic [31:0] PT1   = 32'h0240_0007;
    localparam logic [31:0] NEXT  = 32'h0240_0007;
    localparam logic [31:0] MUL_A = {7'b0010000, 4'd2, 4'd3, 1'b0, 16'd5};
    localparam logic [31:0] MUL_B = {7'b0111000, 4'd5, 4'd6, 1'b0, 16'h0042};

    typedef struct {
        logic [31:0] word;
        logic        is_ucode;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_instruction;
    logic        fetch_valid;
    logic        fetch_stall;
    logic [6:0]  mul_opcode;
    logic [15:0] immediate;
    logic [3:0]  dest_reg, reg1, reg2;
    logic [3:0]  ghost_pc;
    logic [31:0] ucode_instruction = '0;
    logic        ucode_done = 1'b0;
    logic        ubr_taken;
    logic [3:0]  ubr_target;
    logic [31:0] issue_instruction;
    logic        issue_valid, issue_is_ucode, ucode_err;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   err_pulses = 0;
    exp_t exp_q[$];

    ucode_sequencer #(.UPC_W(4), .MAX_UCYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .fetch_instruction(fetch_instruction), .fetch_valid(fetch_valid),
        .fetch_stall(fetch_stall),
        .mul_opcode(mul_opcode), .immediate(immediate), .dest_reg(dest_reg),
        .reg1(reg1), .reg2(reg2), .ghost_pc(ghost_pc),
        .ucode_instruction(ucode_instruction), .ucode_done(ucode_done),
        .ubr_taken(ubr_taken), .ubr_target(ubr_target),
        .issue_instruction(issue_instruction), .issue_valid(issue_valid),
        .issue_is_ucode(issue_is_ucode), .ucode_err(ucode_err)
    );

    always #5 clk = ~clk;

    // ROM contents: word 5 is the halt word, all others ordinary.
    function automatic logic [31:0] rom_word(input logic [3:0] a);
        return (a == 4'd5) ? 32'hD000_0005 : (32'hA000_0000 | {28'd0, a});
    endfunction

    always @(posedge clk) begin
        ucode_instruction <= rom_word(ghost_pc);
        ucode_done        <= (ucode_instruction[31:28] == 4'hD);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic push(input logic [31:0] w, input logic u);
        exp_t e;
        e.word = w;
        e.is_ucode = u;
        exp_q.push_back(e);
    endtask

    task automatic push_seq();
        for (int i = 0; i < 5; i++) push(rom_word(4'(i)), 1'b1);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Monitor: every issued word must match the head of the queue.
    always @(negedge clk) begin
        if (ucode_err) err_pulses++;
        if (issue_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_issue: got %h expected none at %0t", issue_instruction, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("issue_word", issue_instruction, e.word);
                check("issue_is_ucode", {31'd0, issue_is_ucode}, {31'd0, e.is_ucode});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1;
        fetch_instruction = '0;
        fetch_valid = 1'b0;
        ubr_taken = 1'b0;
        ubr_target = '0;
        #1 rst = 1'b0;
        #2;
        check("rst_fetch_stall", {31'd0, fetch_stall}, 0);
        check("rst_issue_valid", {31'd0, issue_valid}, 0);
        check("rst_ucode_err", {31'd0, ucode_err}, 0);
        check("rst_ghost_pc", {28'd0, ghost_pc}, 0);
        check("rst_mul_opcode", {25'd0, mul_opcode}, 0);
        #9 rst = 1'b1;

        // Passthrough, then a multiply on the bus with fetch_valid low.
        next_cycle(); fetch_instruction = PT0; fetch_valid = 1'b1; push(PT0, 1'b0);
        sample(); check("pt0_stall", {31'd0, fetch_stall}, 0);
        check("pt0_valid", {31'd0, issue_valid}, 1);
        next_cycle(); fetch_instruction = PT1; push(PT1, 1'b0);
        sample(); check("pt1_valid", {31'd0, issue_valid}, 1);
        next_cycle(); fetch_instruction = MUL_A; fetch_valid = 1'b0;
        sample(); check("novalid_issue", {31'd0, issue_valid}, 0);
        next_cycle(); sample(); check("novalid_stall", {31'd0, fetch_stall}, 0);

        // Basic multiply sequence.
        next_cycle(); fetch_instruction = MUL_A; fetch_valid = 1'b1;
        sample(); check("mul_consumed", {31'd0, issue_valid}, 0);
        push_seq(); push(NEXT, 1'b0);
        next_cycle(); fetch_instruction = NEXT;
        sample();
        check("c1_stall", {31'd0, fetch_stall}, 1);
        check("c1_mul_opcode", {25'd0, mul_opcode}, 32'h10);
        check("c1_immediate", {16'd0, immediate}, 5);
        check("c1_dest_reg", {28'd0, dest_reg}, 2);
        check("c1_reg1", {28'd0, reg1}, 3);
        check("c1_ghost_pc", {28'd0, ghost_pc}, 0);
        for (int i = 0; i < 5; i++) begin
            next_cycle(); sample();
            check("word_valid", {31'd0, issue_valid}, 1);
            check("word_ghost_pc", {28'd0, ghost_pc}, i + 1);
        end
        next_cycle(); sample(); check("halt_not_issued", {31'd0, issue_valid}, 0);
        next_cycle(); sample(); check("wait_stall", {31'd0, fetch_stall}, 1);
        next_cycle(); sample();
        check("done_stall", {31'd0, fetch_stall}, 0);
        check("done_mul_opcode", {25'd0, mul_opcode}, 0);
        check("done_immediate_held", {16'd0, immediate}, 5);
        next_cycle(); fetch_valid = 1'b0;

        // Micro-branch back to word 1 three times, then fall through to halt.
        next_cycle(); fetch_instruction = MUL_A; fetch_valid = 1'b1;
        push_seq();
        for (int r = 0; r < 3; r++)
            for (int i = 1; i < 5; i++) push(rom_word(4'(i)), 1'b1);
        sample();
        next_cycle(); fetch_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            next_cycle(); sample();
        end
        for (int r = 0; r < 3; r++) begin
            next_cycle(); ubr_taken = 1'b1; ubr_target = 4'd1;
            sample(); check("ubr_squash_t", {31'd0, issue_valid}, 0);
            next_cycle(); ubr_taken = 1'b0;
            sample(); check("ubr_squash_t1", {31'd0, issue_valid}, 0);
            check("ubr_ghost_pc", {28'd0, ghost_pc}, 1);
            for (int i = 1; i < 5; i++) begin
                next_cycle(); sample();
                check("ubr_word_valid", {31'd0, issue_valid}, 1);
            end
        end
        next_cycle(); sample(); check("ubr_halt", {31'd0, issue_valid}, 0);
        next_cycle(); sample();
        next_cycle(); sample(); check("ubr_end_stall", {31'd0, fetch_stall}, 0);
        check("ubr_no_err", err_pulses, 0);

        // Timeout: branch taken forever.
        next_cycle(); fetch_instruction = MUL_A; fetch_valid = 1'b1;
        sample();
        next_cycle(); fetch_valid = 1'b0; ubr_taken = 1'b1; ubr_target = 4'd1;
        sample(); k = 1;
        while (!ucode_err && k < 100) begin
            next_cycle(); k++; sample();
        end
        check("timeout_cycle", k, 65);
        check("timeout_stall", {31'd0, fetch_stall}, 0);
        check("timeout_mul_opcode", {25'd0, mul_opcode}, 0);
        check("timeout_ghost_pc", {28'd0, ghost_pc}, 0);
        next_cycle(); ubr_taken = 1'b0;
        sample(); check("timeout_err_one_cycle", {31'd0, ucode_err}, 0);
        check("timeout_err_count", err_pulses, 1);

        // ghost_pc overflow: redirect to the last micro-address.
        next_cycle(); fetch_instruction = MUL_A; fetch_valid = 1'b1;
        sample();
        next_cycle(); fetch_valid = 1'b0; push(rom_word(4'd0), 1'b1);
        sample();
        next_cycle(); sample(); check("ovf_word0", {31'd0, issue_valid}, 1);
        next_cycle(); ubr_taken = 1'b1; ubr_target = 4'd15;
        sample();
        next_cycle(); ubr_taken = 1'b0;
        sample(); check("ovf_ghost_pc", {28'd0, ghost_pc}, 15);
        next_cycle(); sample();
        check("ovf_err", {31'd0, ucode_err}, 1);
        check("ovf_stall", {31'd0, fetch_stall}, 0);
        check("ovf_ghost_pc_clr", {28'd0, ghost_pc}, 0);

        // Reset mid-RUN at ghost_pc = 3.
        next_cycle(); fetch_instruction = MUL_A; fetch_valid = 1'b1;
        push(rom_word(4'd0), 1'b1); push(rom_word(4'd1), 1'b1);
        sample();
        next_cycle(); fetch_valid = 1'b0;
        next_cycle(); next_cycle(); next_cycle();
        #2 check("prerst_ghost_pc", {28'd0, ghost_pc}, 3);
        rst = 1'b0;
        #1;
        check("mrst_stall", {31'd0, fetch_stall}, 0);
        check("mrst_issue_valid", {31'd0, issue_valid}, 0);
        check("mrst_is_ucode", {31'd0, issue_is_ucode}, 0);
        check("mrst_ghost_pc", {28'd0, ghost_pc}, 0);
        check("mrst_mul_opcode", {25'd0, mul_opcode}, 0);
        check("mrst_immediate", {16'd0, immediate}, 0);
        sample(); #1 rst = 1'b1;
        next_cycle(); fetch_instruction = NEXT; fetch_valid = 1'b1; push(NEXT, 1'b0);
        sample(); check("post_rst_pass", {31'd0, issue_valid}, 1);
        next_cycle(); fetch_valid = 1'b0;

        // Back-to-back multiplies.
        next_cycle(); fetch_instruction = MUL_A; fetch_valid = 1'b1;
        push_seq(); push_seq(); push(NEXT, 1'b0);
        sample();
        next_cycle(); fetch_instruction = MUL_B;
        sample(); k = 1;
        while (fetch_stall && k < 40) begin
            next_cycle(); k++; sample();
        end
        check("b2b_first_end", k, 9);
        check("b2b_second_consumed", {31'd0, issue_valid}, 0);
        next_cycle(); fetch_instruction = NEXT;
        sample(); k = 10;
        check("b2b_mul_opcode", {25'd0, mul_opcode}, 32'h38);
        check("b2b_immediate", {16'd0, immediate}, 32'h42);
        check("b2b_stall", {31'd0, fetch_stall}, 1);
        while (fetch_stall && k < 60) begin
            next_cycle(); k++; sample();
        end
        check("b2b_second_end", k, 18);
        check("b2b_next_issued", {31'd0, issue_valid}, 1);
        next_cycle(); fetch_valid = 1'b0;
        next_cycle(); sample();

        check("queue_drained", exp_q.size(), 0);
        check("total_err_pulses", err_pulses, 2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
